// File: rtl/solo_squash.sv
// rtl/solo_squash.sv - single-player squash game with direct 640x480 VGA output
//
// Optional feature macro: SOLO_SQUASH_SOUND_EN (bounce tone on the speaker pin).
// Without it the speaker is tied low and no tone counter exists.
//
// Ports:
//   clk      in   pixel clock, 25 MHz
//   rst_n    in   asynchronous active-low reset
//   ena      in   design enable, ignored
//   ui_in    in   [0]=pause [1]=new_game [2]=down [3]=up (active-high), [7:4] unused
//   uo_out   out  [0]=blue [1]=green [2]=red [3]=hsync [4]=vsync [5]=speaker [6]=col0 [7]=row0
//   uio_in   in   unused
//   uio_out  out  constant 0
//   uio_oe   out  constant 0
module solo_squash (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [9:0] H_LAST       = 10'd799;
   localparam logic [9:0] V_LAST       = 10'd524;
   localparam logic [9:0] H_VIS        = 10'd640;
   localparam logic [9:0] V_VIS        = 10'd480;
   localparam logic [9:0] HS_FIRST     = 10'd656;
   localparam logic [9:0] HS_LAST      = 10'd751;
   localparam logic [9:0] VS_FIRST     = 10'd490;
   localparam logic [9:0] VS_LAST      = 10'd491;
   localparam logic [9:0] TICK_LINE    = 10'd480;
   localparam logic [9:0] WALL         = 10'd32;
   localparam logic [9:0] WALL_BOTTOM  = 10'd448;
   localparam logic [9:0] BALL_SIZE    = 10'd16;
   localparam logic [9:0] BALL_X0      = 10'd320;
   localparam logic [9:0] BALL_Y0      = 10'd240;
   localparam logic [9:0] BALL_STEP    = 10'd2;
   localparam logic [9:0] BALL_Y_MAX   = 10'd432;
   localparam logic [9:0] BALL_OUT_X   = 10'd640;
   localparam logic [9:0] PADDLE_HIT_X = 10'd584;
   localparam logic [9:0] PADDLE_X0    = 10'd600;
   localparam logic [9:0] PADDLE_X1    = 10'd615;
   localparam logic [9:0] PADDLE_H     = 10'd64;
   localparam logic [9:0] PADDLE_Y0    = 10'd208;
   localparam logic [9:0] PADDLE_MIN   = 10'd32;
   localparam logic [9:0] PADDLE_MAX   = 10'd384;
   localparam logic [9:0] PADDLE_STEP  = 10'd4;

   // Buttons are handled as active-low internally.
   logic pause_n, new_game_n, down_n, up_n;
   assign pause_n    = ~ui_in[0];
   assign new_game_n = ~ui_in[1];
   assign down_n     = ~ui_in[2];
   assign up_n       = ~ui_in[3];

   logic [9:0] hcount, vcount;
   logic [9:0] ball_x, ball_y, paddle_y;
   logic       dir_x, dir_y;          // 1 = moving towards larger coordinates
   logic       game_over;

   // Raster counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount <= '0;
         vcount <= '0;
      end else if (hcount == H_LAST) begin
         hcount <= '0;
         vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
         hcount <= hcount + 10'd1;
      end
   end

   logic tick, run_tick, ball_load;
   assign tick      = (hcount == 10'd0) && (vcount == TICK_LINE);
   assign run_tick  = tick && pause_n;
   // new_game still acts while paused, so the ball registers load on it too.
   assign ball_load = tick && (pause_n || !new_game_n);

   // Next ball state. Bounce tests use the pre-move position and the
   // step is taken in the post-bounce direction.
   logic [9:0] nx_ball_x, nx_ball_y;
   logic       nx_dir_x, nx_dir_y, nx_game_over, bounce, paddle_hit;

   assign paddle_hit = (ball_x == PADDLE_HIT_X) &&
                       ((ball_y + BALL_SIZE) > paddle_y) &&
                       (ball_y < (paddle_y + PADDLE_H));

   always_comb begin
      nx_ball_x    = ball_x;
      nx_ball_y    = ball_y;
      nx_dir_x     = dir_x;
      nx_dir_y     = dir_y;
      nx_game_over = game_over;
      bounce       = 1'b0;
      if (!new_game_n) begin
         nx_ball_x    = BALL_X0;
         nx_ball_y    = BALL_Y0;
         nx_dir_x     = 1'b1;
         nx_dir_y     = 1'b1;
         nx_game_over = 1'b0;
      end else if (!game_over) begin
         if (ball_x >= BALL_OUT_X) begin
            nx_game_over = 1'b1;
         end else begin
            if (ball_y <= WALL)       nx_dir_y = 1'b1;
            if (ball_y >= BALL_Y_MAX) nx_dir_y = 1'b0;
            if (ball_x <= WALL)       nx_dir_x = 1'b1;
            if (paddle_hit)           nx_dir_x = 1'b0;
            // A bounce is an actual change of direction on either axis.
            bounce    = (nx_dir_x != dir_x) || (nx_dir_y != dir_y);
            nx_ball_x = nx_dir_x ? ball_x + BALL_STEP : ball_x - BALL_STEP;
            nx_ball_y = nx_dir_y ? ball_y + BALL_STEP : ball_y - BALL_STEP;
         end
      end
   end

   // Next paddle position, clamped to the playfield; both buttons cancel.
   logic [9:0] nx_paddle_y;
   always_comb begin
      nx_paddle_y = paddle_y;
      if (!up_n && down_n) begin
         nx_paddle_y = (paddle_y <= PADDLE_MIN + PADDLE_STEP) ? PADDLE_MIN
                                                              : paddle_y - PADDLE_STEP;
      end else if (up_n && !down_n) begin
         nx_paddle_y = (paddle_y >= PADDLE_MAX - PADDLE_STEP) ? PADDLE_MAX
                                                              : paddle_y + PADDLE_STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ball_x    <= BALL_X0;
         ball_y    <= BALL_Y0;
         dir_x     <= 1'b1;
         dir_y     <= 1'b1;
         game_over <= 1'b0;
         paddle_y  <= PADDLE_Y0;
      end else begin
         if (ball_load) begin
            ball_x    <= nx_ball_x;
            ball_y    <= nx_ball_y;
            dir_x     <= nx_dir_x;
            dir_y     <= nx_dir_y;
            game_over <= nx_game_over;
         end
         if (run_tick) begin
            paddle_y <= nx_paddle_y;
         end
      end
   end

   logic speaker;
`ifdef SOLO_SQUASH_SOUND_EN
   logic [3:0] tone_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tone_cnt <= '0;
      end else if (run_tick) begin
         if (bounce)
            tone_cnt <= 4'd8;
         else if (tone_cnt != 4'd0)
            tone_cnt <= tone_cnt - 4'd1;
      end
   end
   // v[3] toggles every 8 lines: 25 MHz / 800 / 16 is roughly 1.95 kHz.
   assign speaker = vcount[3] && (tone_cnt != 4'd0);

   logic unused_inputs;
   assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4]};
`else
   assign speaker = 1'b0;

   logic unused_inputs;
   assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4], bounce};
`endif

   // Pixel generation, combinational from counters and state.
   logic visible, ball_px, paddle_px, wall_px;
   logic [2:0] rgb;   // {red, green, blue}

   assign visible   = (hcount < H_VIS) && (vcount < V_VIS);
   assign ball_px   = !game_over &&
                      (hcount >= ball_x) && (hcount < ball_x + BALL_SIZE) &&
                      (vcount >= ball_y) && (vcount < ball_y + BALL_SIZE);
   assign paddle_px = (hcount >= PADDLE_X0) && (hcount <= PADDLE_X1) &&
                      (vcount >= paddle_y) && (vcount < paddle_y + PADDLE_H);
   assign wall_px   = (vcount < WALL) || (vcount >= WALL_BOTTOM) || (hcount < WALL);

   always_comb begin
      rgb = 3'b000;
      if (visible) begin
         if (ball_px)
            rgb = 3'b110;
         else if (paddle_px)
            rgb = 3'b011;
         else if (wall_px)
            rgb = 3'b010;
      end
   end

   logic hsync, vsync, col0, row0;
   assign hsync = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
   assign vsync = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
   assign col0  = (hcount == 10'd0);
   assign row0  = (vcount == 10'd0);

   assign uo_out  = {row0, col0, speaker, vsync, hsync, rgb};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_solo_squash.sv
// tb/tb_solo_squash.sv - self-checking bench for solo_squash
module tb_solo_squash;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena = 1'b1;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   solo_squash dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int shown = 0;
   bit chk_en = 1'b0;

   // Reference model of the game, in plain integers.
   int mh, mv;              // raster position
   int mbx, mby;            // ball top-left
   int mdx, mdy;            // +1 / -1
   int mpy;                 // paddle top
   int mtone;
   bit mover;

   logic [9:0] g_x, g_y;    // jump targets for the raster counters

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mh = 0; mv = 0;
      mbx = 320; mby = 240; mdx = 1; mdy = 1;
      mpy = 208; mover = 1'b0; mtone = 0;
   endtask

   task automatic model_tick();
      bit p  = ui_in[0];
      bit ng = ui_in[1];
      bit dn = ui_in[2];
      bit up = ui_in[3];
      bit hit = 1'b0;
      int ndx, ndy;
      if (ng) begin
         mbx = 320; mby = 240; mdx = 1; mdy = 1; mover = 1'b0;
      end
      if (p) return;
      if (!ng && !mover) begin
         if (mbx >= 640) begin
            mover = 1'b1;
         end else begin
            ndx = mdx; ndy = mdy;
            if (mby <= 32)  ndy = 1;
            if (mby >= 432) ndy = -1;
            if (mbx <= 32)  ndx = 1;
            if (mbx == 584 && mby + 16 > mpy && mby < mpy + 64) ndx = -1;
            hit = (ndx != mdx) || (ndy != mdy);
            mdx = ndx; mdy = ndy;
            mbx = mbx + 2 * mdx;
            mby = mby + 2 * mdy;
         end
      end
      if (up && !dn)      mpy = (mpy - 4 < 32)  ? 32  : mpy - 4;
      else if (dn && !up) mpy = (mpy + 4 > 384) ? 384 : mpy + 4;
      if (hit)            mtone = 8;
      else if (mtone > 0) mtone = mtone - 1;
   endtask

   task automatic model_edge();
      if (rst_n) begin
         if (mh == 0 && mv == 480) model_tick();
         mh = mh + 1;
         if (mh == 800) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
         end
      end
   endtask

   function automatic logic [7:0] expect_out(input int h, input int v);
      logic [2:0] rgb = 3'b000;
      logic spk = 1'b0;
      if (h < 640 && v < 480) begin
         if (!mover && h >= mbx && h < mbx + 16 && v >= mby && v < mby + 16)
            rgb = 3'b110;
         else if (h >= 600 && h <= 615 && v >= mpy && v < mpy + 64)
            rgb = 3'b011;
         else if (v < 32 || v >= 448 || h < 32)
            rgb = 3'b010;
      end
`ifdef SOLO_SQUASH_SOUND_EN
      spk = (((v / 8) % 2) == 1) && (mtone != 0);
`endif
      return {v == 0, h == 0, spk, !(v == 490 || v == 491), !(h >= 656 && h <= 751), rgb};
   endfunction

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [7:0] e;
         e = expect_out(mh, mv);
         tests++;
         if (uo_out !== e) begin
            fails++;
            if (shown < 20) begin
               shown++;
               $display("FAIL uo_out at h=%0d v=%0d: got %b expected %b", mh, mv, uo_out, e);
            end
         end
         tests++;
         if ({uio_out, uio_oe} !== 16'h0000) begin
            fails++;
            if (shown < 20) begin
               shown++;
               $display("FAIL uio_const: got %h expected 0000", {uio_out, uio_oe});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      #2;
   endtask

   // Jump the raster to (x,y); only called right after step().
   task automatic go_to(input int x, input int y);
      g_x = x[9:0];
      g_y = y[9:0];
      force dut.hcount = g_x;
      force dut.vcount = g_y;
      #1;
      release dut.hcount;
      release dut.vcount;
      mh = x; mv = y;
   endtask

   task automatic check_px(input string name, input int x, input int y, input int rgb);
      step();
      go_to(x, y);
      #1;
      check(name, int'(uo_out[2:0]), rgb);
   endtask

   // One game tick, then scan the ball, the paddle and a v[3]=1 line.
   task automatic do_tick();
      step();
      go_to(0, 480);
      step();
      go_to((mbx >= 4) ? mbx - 4 : 0, mby);
      repeat (24) step();
      go_to(596, mpy);
      repeat (24) step();
      go_to(0, 8);
      repeat (2) step();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: bench did not reach its summary in time");
      $fatal(1);
   end

   initial begin
      int hs_fall[$];
      int hs_low, vs_low, vs_first, col0_cnt, row0_cnt, k;
      logic prev;

      rst_n  = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'($urandom);
      model_reset();
      chk_en = 1'b1;

      // Reset state shows pixel (0,0): green wall, syncs high, col0/row0 high.
      step();
      check("reset_uo_out", int'(uo_out), 8'hDA);
      check("reset_uio_out", int'(uio_out), 0);
      check("reset_uio_oe", int'(uio_oe), 0);
      step();
      rst_n = 1'b1;

      // Free-run: horizontal timing, col0 and row0.
      hs_low = 0; col0_cnt = 0; row0_cnt = 0; prev = 1'b1;
      for (int n = 0; n < 1700; n++) begin
         if (prev && !uo_out[3]) hs_fall.push_back(n);
         if (!uo_out[3]) hs_low++;
         if (uo_out[6]) col0_cnt++;
         if (uo_out[7]) row0_cnt++;
         prev = uo_out[3];
         step();
      end
      check("hsync_fall_count", hs_fall.size(), 2);
      if (hs_fall.size() == 2) begin
         check("hsync_first_fall", hs_fall[0], 656);
         check("hsync_period", hs_fall[1] - hs_fall[0], 800);
      end
      check("hsync_low_clocks", hs_low, 192);
      check("col0_count", col0_cnt, 3);
      check("row0_count", row0_cnt, 800);

      // Vertical sync window.
      step();
      go_to(0, 488);
      vs_low = 0; vs_first = -1;
      for (int n = 0; n < 3300; n++) begin
         if (!uo_out[4]) begin
            vs_low++;
            if (vs_first < 0) vs_first = n;
         end
         step();
      end
      check("vsync_low_clocks", vs_low, 1600);
      check("vsync_first_low", vs_first, 1600);

      // Ten frames, no buttons.
      ui_in = 8'h00;
      repeat (10) do_tick();
      check("model_ball_x_10", mbx, 340);
      check("model_ball_y_10", mby, 260);
      check_px("ball_pixel_340_260", 340, 260, 3'b110);
      check_px("bg_pixel_339_260", 339, 260, 3'b000);
      check_px("ball_pixel_355_275", 355, 275, 3'b110);
      check_px("bg_pixel_356_260", 356, 260, 3'b000);

      // Pause with up held: nothing moves.
      ui_in = 8'h09;
      repeat (5) do_tick();
      check("model_paddle_paused", mpy, 208);
      check("model_ball_paused", mbx, 340);
      check_px("paddle_top_208", 600, 208, 3'b011);
      check_px("above_paddle_207", 600, 207, 3'b000);

      // Up for 60 frames clamps at 32.
      ui_in = 8'h08;
      repeat (60) do_tick();
      check("model_paddle_up", mpy, 32);
      check_px("paddle_top_32", 600, 32, 3'b011);
      check_px("wall_above_paddle", 600, 31, 3'b010);
      check_px("below_paddle_96", 600, 96, 3'b000);

      // Paddle parked high: ball misses and the game ends.
      ui_in = 8'h00;
      k = 0;
      while (!mover && k < 200) begin
         do_tick();
         k++;
`ifdef SOLO_SQUASH_SOUND_EN
         if (k == 27) begin
            check("model_tone_loaded", mtone, 8);
            step();
            go_to(0, 8);
            #1;
            check("speaker_on", int'(uo_out[5]), 1);
         end
         if (k == 34) check("model_tone_last", mtone, 1);
         if (k == 35) check("model_tone_done", mtone, 0);
`else
         if (k == 27) begin
            step();
            go_to(0, 8);
            #1;
            check("speaker_off", int'(uo_out[5]), 0);
         end
`endif
      end
      check("ticks_to_game_over", k, 91);
      check("model_ball_x_out", mbx, 640);

      // new_game restarts the ball, paddle untouched.
      ui_in = 8'h02;
      do_tick();
      ui_in = 8'h00;
      check("model_new_game_x", mbx, 320);
      check("model_new_game_y", mby, 240);
      check("model_new_game_paddle", mpy, 32);
      check_px("new_ball_320_240", 320, 240, 3'b110);
      check_px("new_ball_335_255", 335, 255, 3'b110);
      check_px("bg_336_240", 336, 240, 3'b000);

      // Down for 100 frames clamps at 384.
      ui_in = 8'h04;
      repeat (100) do_tick();
      check("model_paddle_down", mpy, 384);
      check_px("paddle_bottom_447", 600, 447, 3'b011);
      check_px("wall_below_paddle", 600, 448, 3'b010);

      // Random buttons, with an asynchronous reset in the middle.
      for (int t = 0; t < 300; t++) begin
         ui_in    = 8'($urandom);
         ui_in[0] = ($urandom_range(0, 7) == 0);
         ui_in[1] = ($urandom_range(0, 15) == 0);
         if (t == 150) begin
            step();
            rst_n = 1'b0;
            model_reset();
            #1;
            check("midrun_reset_uo_out", int'(uo_out), 8'hDA);
            repeat (3) step();
            rst_n = 1'b1;
         end
         do_tick();
      end

      step();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
